// File: rtl/gpio_pkg.sv
// Shared register map and limits for the gpio_bank IO-bus GPIO block.
package gpio_pkg;
  localparam logic [1:0] GPIO_REG_DATA  = 2'd0;
  localparam logic [1:0] GPIO_REG_DIR   = 2'd1;
  localparam logic [1:0] GPIO_REG_IE    = 2'd2;
  localparam logic [1:0] GPIO_REG_IFLAG = 2'd3;
  localparam int unsigned MAX_PORTS     = 4;
endpackage

// File: rtl/gpio_sync.sv
// Per-port input synchroniser with a trailing edge-detect flop.
// The edge flop exists only when GPIO_BANK_IRQ_EN is defined; otherwise rise is tied 0.
module gpio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = pin_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign sync_in = stage_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] sync_d_q;
  logic [WIDTH-1:0] sync_d_d;

  assign sync_d_d = sync_in;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) sync_d_q <= '0;
    else         sync_d_q <= sync_d_d;
  end

  assign rise = sync_in & ~sync_d_q;
`else
  assign rise = '0;
`endif
endmodule

// File: rtl/gpio_bank.sv
// Multi-port GPIO on the 8-bit IO bus: DATA/DIR per port, optional IE/IFLAG edge
// interrupts (GPIO_BANK_IRQ_EN) ORed into irq_gpio.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned NPORTS      = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [7:0]              io_addr,
  input  logic                    io_en,
  input  logic                    io_we,
  input  logic [31:0]             io_data_write,
  output logic [31:0]             io_data_read,
  output logic                    irq_gpio,
  output logic [NPORTS*WIDTH-1:0] gpio_out,
  output logic [NPORTS*WIDTH-1:0] gpio_dir,
  input  logic [NPORTS*WIDTH-1:0] gpio_in
);
  localparam int unsigned NBITS = NPORTS * WIDTH;

  logic [NBITS-1:0] out_q, out_d, dir_q, dir_d;
  logic [NBITS-1:0] sync_all, rise_all;
  logic [1:0]       reg_sel;
  logic [31:0]      port_sel;
  logic             port_ok, wr;
  logic [WIDTH-1:0] wdata, rdata;
  logic [45:0]      unused_bits;

  assign reg_sel     = io_addr[3:2];
  assign port_sel    = 32'(io_addr[5:4]);
  assign port_ok     = (port_sel < NPORTS) && (NPORTS <= MAX_PORTS);
  assign wr          = io_en && io_we && port_ok;
  assign wdata       = io_data_write[WIDTH-1:0];
  assign unused_bits = {io_addr[7:6], io_addr[1:0], io_data_write, rise_all[NBITS-1:NBITS-1],
                        9'(rise_all[0])};

  for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .resetb  (resetb),
      .pin_in  (gpio_in[gp*WIDTH +: WIDTH]),
      .sync_in (sync_all[gp*WIDTH +: WIDTH]),
      .rise    (rise_all[gp*WIDTH +: WIDTH])
    );
  end

`ifdef GPIO_BANK_IRQ_EN
  logic [NBITS-1:0] ie_q, ie_d, iflag_q, iflag_d, clr_mask;

  // A new edge in the same cycle as a W1C on that bit must survive: set is ORed in last.
  always_comb begin
    ie_d     = ie_q;
    clr_mask = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (wr && port_sel == p) begin
        if (reg_sel == GPIO_REG_IE)    ie_d[p*WIDTH +: WIDTH]     = wdata;
        if (reg_sel == GPIO_REG_IFLAG) clr_mask[p*WIDTH +: WIDTH] = wdata;
      end
    end
    iflag_d = (iflag_q & ~clr_mask) | (rise_all & ~dir_q & ie_q);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ie_q    <= '0;
      iflag_q <= '0;
    end else begin
      ie_q    <= ie_d;
      iflag_q <= iflag_d;
    end
  end

  assign irq_gpio = |(iflag_q & ie_q);
`else
  assign irq_gpio = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (wr && port_sel == p) begin
        if (reg_sel == GPIO_REG_DATA) out_d[p*WIDTH +: WIDTH] = wdata;
        if (reg_sel == GPIO_REG_DIR)  dir_d[p*WIDTH +: WIDTH] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (io_en && port_ok && port_sel == p) begin
        case (reg_sel)
          GPIO_REG_DATA: rdata = (dir_q[p*WIDTH +: WIDTH] & out_q[p*WIDTH +: WIDTH]) |
                                 (~dir_q[p*WIDTH +: WIDTH] & sync_all[p*WIDTH +: WIDTH]);
          GPIO_REG_DIR:  rdata = dir_q[p*WIDTH +: WIDTH];
`ifdef GPIO_BANK_IRQ_EN
          GPIO_REG_IE:    rdata = ie_q[p*WIDTH +: WIDTH];
          GPIO_REG_IFLAG: rdata = iflag_q[p*WIDTH +: WIDTH];
`endif
          default:       rdata = '0;
        endcase
      end
    end
  end

  assign io_data_read = 32'(rdata);
  assign gpio_out     = out_q;
  assign gpio_dir     = dir_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (NPORTS=2, WIDTH=8, SYNC_STAGES=2),
// covering both the GPIO_BANK_IRQ_EN build and the plain build.
module tb_gpio_bank;
  logic        clk = 1'b0;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en, io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        irq_gpio;
  logic [15:0] gpio_out, gpio_dir, gpio_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  gpio_bank #(.NPORTS(2), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .irq_gpio      (irq_gpio),
    .gpio_out      (gpio_out),
    .gpio_dir      (gpio_dir),
    .gpio_in       (gpio_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] addr(input int unsigned port, input int unsigned rsel);
    addr = 8'((port << 4) | (rsel << 2));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int unsigned port, input int unsigned rsel, input logic [31:0] d);
    @(negedge clk);
    io_en = 1'b1; io_we = 1'b1; io_addr = addr(port, rsel); io_data_write = d;
    @(posedge clk);
    #1;
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int unsigned port, input int unsigned rsel,
                        input logic [31:0] exp);
    logic [31:0] d;
    io_en = 1'b1; io_we = 1'b0; io_addr = addr(port, rsel);
    #1 d = io_data_read;
    io_en = 1'b0;
    check(tag, d, exp);
  endtask

  initial begin
    resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0; gpio_in = '0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;

    // Reset asserted mid-cycle over live state
    wr(0, 1, 32'hFF);
    wr(0, 0, 32'h3C);
    check("pre_reset_out", 32'(gpio_out), 32'h003C);
    #2 resetb = 1'b0;
    #1;
    check("reset_out", 32'(gpio_out), 32'h0);
    check("reset_dir", 32'(gpio_dir), 32'h0);
    check("reset_irq", 32'(irq_gpio), 32'h0);
    chk_rd("reset_data_p0", 0, 0, 32'h0);
    @(negedge clk) resetb = 1'b1;

    // DIR/DATA with mixed direction on port 1
    wr(1, 1, 32'h0F);
    wr(1, 0, 32'hA5);
    gpio_in = 16'h3000;
    check("gpio_out", 32'(gpio_out), 32'hA500);
    check("gpio_dir", 32'(gpio_dir), 32'h0F00);
    @(posedge clk); #1;
    chk_rd("data_p1_1cyc", 1, 0, 32'h05);
    @(posedge clk); #1;
    chk_rd("data_p1_2cyc", 1, 0, 32'h35);
    chk_rd("dir_p1", 1, 1, 32'h0F);

    // Out-of-range port, disabled strobe, upper read bits
    wr(3, 0, 32'hFF);
    wr(3, 1, 32'hFF);
    check("p3_no_out_change", 32'(gpio_out), 32'hA500);
    check("p3_no_dir_change", 32'(gpio_dir), 32'h0F00);
    chk_rd("p3_read", 3, 1, 32'h0);
    io_addr = addr(1, 1); io_en = 1'b0;
    #1 check("read_no_en", io_data_read, 32'h0);
    wr(0, 1, 32'hFF);
    wr(0, 0, 32'hFFFF_FF5A);
    chk_rd("upper_bits_zero", 0, 0, 32'h0000_005A);
    wr(0, 1, 32'h00);

`ifdef GPIO_BANK_IRQ_EN
    wr(0, 2, 32'h01);
    gpio_in[0] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk_rd("iflag_2cyc", 0, 3, 32'h00);
    check("irq_2cyc", 32'(irq_gpio), 32'h0);
    @(posedge clk); #1;
    chk_rd("iflag_3cyc", 0, 3, 32'h01);
    check("irq_3cyc", 32'(irq_gpio), 32'h1);
    wr(0, 3, 32'h01);
    chk_rd("iflag_w1c", 0, 3, 32'h00);
    check("irq_w1c", 32'(irq_gpio), 32'h0);

    // W1C colliding with a fresh rise on the same bit
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[0] = 1'b1;
    @(posedge clk); @(posedge clk);
    wr(0, 3, 32'h01);
    chk_rd("collision_set_wins", 0, 3, 32'h01);
    check("collision_irq", 32'(irq_gpio), 32'h1);

    // Masking keeps the flag; DIR change keeps it too
    wr(0, 2, 32'h00);
    check("masked_irq", 32'(irq_gpio), 32'h0);
    chk_rd("masked_iflag", 0, 3, 32'h01);
    wr(0, 1, 32'h01);
    chk_rd("dir_keeps_iflag", 0, 3, 32'h01);
    wr(0, 3, 32'hFF);
    chk_rd("iflag_clear_all", 0, 3, 32'h00);

    // Output pins never flag
    wr(0, 2, 32'h01);
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk_rd("output_pin_no_flag", 0, 3, 32'h00);
    check("output_pin_no_irq", 32'(irq_gpio), 32'h0);
`else
    wr(0, 2, 32'hFF);
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 gpio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("noirq_irq", 32'(irq_gpio), 32'h0);
    chk_rd("noirq_ie_reads0", 0, 2, 32'h0);
    chk_rd("noirq_iflag_reads0", 0, 3, 32'h0);
    chk_rd("noirq_data_sync", 0, 0, 32'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
